// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the L1 dcache controller and Data_Memory: absorbs dirty
// evictions in one cycle and drains them in the background. Optional macro: WBUF_FORWARD_EN.
module dcache_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cache_enable_i,
    input  logic                    cache_write_i,
    input  logic [ADDR_W-1:0]       cache_addr_i,
    input  logic [LINE_W-1:0]       cache_data_i,
    output logic                    cache_ack_o,
    output logic [LINE_W-1:0]       cache_data_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_W-1:0]       mem_data_o,
    input  logic                    mem_ack_i,
    input  logic [LINE_W-1:0]       mem_data_i,
    output logic [$clog2(DEPTH):0]  wbuf_count_o,
    output logic                    wbuf_empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = ADDR_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_GAP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [LINE_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               r_ack;
    logic [LINE_W-1:0]  r_cache_data;
    logic               r_pend;
    logic               r_pend_write;
    logic [TAG_W-1:0]   r_pend_tag;
    logic [LINE_W-1:0]  r_pend_data;

    logic               w_req_valid;
    logic               w_req_write;
    logic [TAG_W-1:0]   w_req_tag;
    logic [LINE_W-1:0]  w_req_data;
    logic               w_lock;
    logic               w_pop;
    logic               w_full;
    logic               w_any_hit;
    logic               w_co_hit;
    logic [PTR_W-1:0]   w_co_idx;
    logic               w_do_coal;
    logic               w_do_push;
    logic               w_do_fwd;
    logic               w_rd_go;
    logic               w_rd_done;
    logic               w_done;
    logic               w_unused;

    // A held request replays from the pending registers; new ones are ignored meanwhile.
    assign w_req_valid = r_pend | (cache_enable_i & ~r_ack);
    assign w_req_write = r_pend ? r_pend_write : cache_write_i;
    assign w_req_tag   = r_pend ? r_pend_tag   : cache_addr_i[ADDR_W-1:5];
    assign w_req_data  = r_pend ? r_pend_data  : cache_data_i;
    assign w_unused    = ^cache_addr_i[4:0];

    assign w_lock    = (r_state == S_DRAIN);
    assign w_pop     = w_lock & mem_ack_i;
    assign w_full    = (r_count == CNT_W'(DEPTH)) & ~w_pop;
    assign w_rd_done = (r_state == S_READ) & mem_ack_i;

    // The head under drain never takes a coalesce, so at most one unlocked entry matches.
    always_comb begin
        w_any_hit = 1'b0;
        w_co_hit  = 1'b0;
        w_co_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_tag[i] == w_req_tag)) begin
                w_any_hit = 1'b1;
                if (!(w_lock && (PTR_W'(i) == r_head))) begin
                    w_co_hit = 1'b1;
                    w_co_idx = PTR_W'(i);
                end
            end
        end
    end

    assign w_do_coal = w_req_valid & w_req_write & w_co_hit;
    assign w_do_push = w_req_valid & w_req_write & ~w_co_hit & ~w_full;
    assign w_rd_go   = ~w_any_hit;

`ifdef WBUF_FORWARD_EN
    logic [LINE_W-1:0] w_fwd_data;
    // Newest copy wins: an unlocked duplicate is younger than the locked head.
    assign w_fwd_data = w_co_hit ? r_data[w_co_idx] : r_data[r_head];
    assign w_do_fwd   = w_req_valid & ~w_req_write & w_any_hit;
`else
    assign w_do_fwd   = 1'b0;
`endif

    assign w_done = w_do_coal | w_do_push | w_do_fwd | w_rd_done;

    always_comb begin
        w_state_nxt  = r_state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend && !r_pend_write && w_rd_go) begin
                    w_state_nxt = S_READ;
                end else if (r_count != '0) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[r_head], 5'b0};
                mem_data_o   = r_data[r_head];
                if (mem_ack_i) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_READ: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {r_pend_tag, 5'b0};
                if (mem_ack_i) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_vld        <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_ack        <= 1'b0;
            r_cache_data <= '0;
            r_pend       <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_done;
            // Pop before push: when full, a push reuses the slot freed in the same cycle.
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_do_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_pop);
            if (w_rd_done) begin
                r_cache_data <= mem_data_i;
            end
`ifdef WBUF_FORWARD_EN
            else if (w_do_fwd) begin
                r_cache_data <= w_fwd_data;
            end
`endif
            if (w_done) begin
                r_pend <= 1'b0;
            end else if (w_req_valid && !r_pend) begin
                r_pend       <= 1'b1;
                r_pend_write <= cache_write_i;
                r_pend_tag   <= cache_addr_i[ADDR_W-1:5];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_tag[r_tail]  <= w_req_tag;
            r_data[r_tail] <= w_req_data;
        end
        if (w_do_coal) begin
            r_data[w_co_idx] <= w_req_data;
        end
        if (w_req_valid && !r_pend) begin
            r_pend_data <= cache_data_i;
        end
    end

    assign cache_ack_o  = r_ack;
    assign cache_data_o = r_cache_data;
    assign wbuf_count_o = r_count;
    assign wbuf_empty_o = (r_count == '0) && (r_state != S_DRAIN);

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus random traffic checked against a
// line-level model (a read returns the latest write to its line) and a fixed-latency memory.
module tb_dcache_wb_buffer;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned LAT    = 10;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam logic [LINE_W-1:0] PAT =
        256'h8888_9999_7777_6666_5555_4444_3333_2222_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_0000;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cache_enable_i = 1'b0;
    logic              cache_write_i = 1'b0;
    logic [ADDR_W-1:0] cache_addr_i = '0;
    logic [LINE_W-1:0] cache_data_i = '0;
    logic              cache_ack_o;
    logic [LINE_W-1:0] cache_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic [CW-1:0]     wbuf_count_o;
    logic              wbuf_empty_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk_i = ~clk_i;

    dcache_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cache_enable_i(cache_enable_i), .cache_write_i(cache_write_i),
        .cache_addr_i(cache_addr_i), .cache_data_i(cache_data_i),
        .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .wbuf_count_o(wbuf_count_o), .wbuf_empty_o(wbuf_empty_o)
    );

    function automatic logic [LINE_W-1:0] init_line(input int unsigned l);
        return PAT ^ {8{l - 32'd1}};
    endfunction

    // Memory: acks LAT cycles after a request is first seen, one-cycle ack pulse.
    logic [LINE_W-1:0] mem_arr [64];
    logic [63:0]       mem_seen = '0;
    int unsigned       mem_wcnt [64] = '{default: 0};
    int unsigned       mem_cnt = 0;
    int unsigned       n_wr = 0;
    int unsigned       n_rd = 0;
    int unsigned       rd_wr_snap = 0;
    time               t_wr_ack = 0;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            mem_ack_i <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_ack_i) begin
            mem_ack_i <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_enable_o) begin
            if (mem_cnt == LAT - 1) begin
                mem_ack_i <= 1'b1;
                mem_cnt   <= 0;
                if (mem_write_o) begin
                    mem_arr[mem_addr_o[10:5]]  <= mem_data_o;
                    mem_seen[mem_addr_o[10:5]] <= 1'b1;
                    mem_wcnt[mem_addr_o[10:5]] <= mem_wcnt[mem_addr_o[10:5]] + 1;
                    n_wr     <= n_wr + 1;
                    t_wr_ack <= $time;
                end else begin
                    mem_data_i <= mem_seen[mem_addr_o[10:5]] ? mem_arr[mem_addr_o[10:5]]
                                                             : init_line(32'(mem_addr_o[10:5]));
                    n_rd       <= n_rd + 1;
                    rd_wr_snap <= n_wr;
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // Coherence model: latest value written per line.
    logic [LINE_W-1:0] sh_d [64];
    bit                sh_v [64];

    function automatic logic [LINE_W-1:0] exp_line(input int unsigned l);
        return sh_v[l] ? sh_d[l] : init_line(l);
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                       output int unsigned lat, output logic [LINE_W-1:0] rdata);
        if (cache_ack_o) tick();
        cache_enable_i = 1'b1;
        cache_write_i  = wr;
        cache_addr_i   = addr;
        cache_data_i   = data;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cache_ack_o && lat < 300);
        rdata = cache_data_o;
        chk(wr ? "wr_ack" : "rd_ack", cache_ack_o, 1);
        cache_enable_i = 1'b0;
        if (wr) begin
            sh_v[addr[10:5]] = 1'b1;
            sh_d[addr[10:5]] = data;
        end
    endtask

    task automatic wait_memen(output int unsigned w);
        w = 0;
        while (!mem_enable_o && w < 50) begin
            tick();
            w++;
        end
        chk("mem_enable_seen", mem_enable_o, 1);
    endtask

    task automatic wait_empty(input string tag);
        int unsigned n = 0;
        while (!wbuf_empty_o && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, wbuf_empty_o, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned       lat;
        int unsigned       w;
        int unsigned       rd0;
        int unsigned       wr0;
        int unsigned       c30;
        int unsigned       c38;
        logic [LINE_W-1:0] rd;
        logic [LINE_W-1:0] d;
        logic [LINE_W-1:0] pd;
        bit                pv;

        // Reset state
        repeat (3) tick();
        chk("rst_cache_ack", cache_ack_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_wr", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_cache_data", cache_data_o, 0);
        chk("rst_count", wbuf_count_o, 0);
        chk("rst_empty", wbuf_empty_o, 1);
        rst_i = 1'b1;
        tick();

        // Single eviction then background drain
        d = {8{32'hD1D1_0001}};
        req(1'b1, 32'h0000_0200, d, lat, rd);
        chk("ev1_lat", lat, 1);
        chk("ev1_count", wbuf_count_o, 1);
        chk("ev1_not_empty", wbuf_empty_o, 0);
        wait_memen(w);
        chk("ev1_drain_start", w <= 2, 1);
        chk("ev1_mem_wr", mem_write_o, 1);
        chk("ev1_mem_addr", mem_addr_o, 32'h200);
        chk("ev1_mem_data", mem_data_o, d);
        wait_empty("ev1_empty");
        chk("ev1_count0", wbuf_count_o, 0);
        chk("ev1_mem_line", mem_arr[16], d);

        // Dirty miss: read waits behind in-flight drain, then goes to memory
        req(1'b1, 32'h0000_0400, {8{32'hD2D2_0002}}, lat, rd);
        wait_memen(w);
        rd0 = n_rd;
        wr0 = n_wr;
        req(1'b0, 32'h0000_0020, '0, lat, rd);
        chk("miss_data", rd, PAT);
        chk("miss_after_drain", rd_wr_snap, wr0 + 1);
        chk("miss_one_read", n_rd, rd0 + 1);

        // Read of a line that is draining: forwarded (1 cycle, no read) or served after drain
        wait_empty("fw_pre_empty");
        d = {8{32'hD3D3_0003}};
        req(1'b1, 32'h0000_0040, d, lat, rd);
        wait_memen(w);
        rd0 = n_rd;
        req(1'b0, 32'h0000_0044, '0, lat, rd);
        chk("fw_data", rd, d);
        chk("fw_path", (lat == 1) == (n_rd == rd0), 1);
        wait_empty("fw_empty");

        // Full FIFO: fifth distinct line held until the first drain pops
        for (int k = 0; k < 4; k++) begin
            req(1'b1, 32'h100 + 32'(k) * 32, rnd_line(), lat, rd);
            chk("full_fill_lat", lat, 1);
        end
        chk("full_count4", wbuf_count_o, 4);
        wr0 = n_wr;
        req(1'b1, 32'h0000_0180, rnd_line(), lat, rd);
        chk("full_held", lat > 1, 1);
        chk("full_after_one_pop", n_wr, wr0 + 1);
        chk("full_ack_after_pop", $time - t_wr_ack, 11);
        chk("full_count_stays", wbuf_count_o, 4);
        wait_empty("full_empty");
        for (int k = 0; k < 5; k++) chk("full_mem", mem_arr[8 + k], exp_line(8 + k));

        // Coalesce into a non-head entry; write to the locked head line becomes a new entry
        c30 = mem_wcnt[48];
        c38 = mem_wcnt[56];
        req(1'b1, 32'h0000_0700, {8{32'hDDDD_0700}}, lat, rd);
        wait_memen(w);
        req(1'b1, 32'h0000_0600, {8{32'hDADA_0600}}, lat, rd);
        chk("co_count_a", wbuf_count_o, 2);
        d = {8{32'hDBDB_0600}};
        req(1'b1, 32'h0000_0610, d, lat, rd);
        chk("co_lat", lat, 1);
        chk("co_count_b", wbuf_count_o, 2);
        req(1'b1, 32'h0000_0700, {8{32'hDEDE_0701}}, lat, rd);
        chk("co_locked_push", wbuf_count_o, 3);
        wait_empty("co_empty");
        chk("co_mem_600", mem_arr[48], d);
        chk("co_wr_600", mem_wcnt[48], c30 + 1);
        chk("co_mem_700", mem_arr[56], exp_line(56));
        chk("co_wr_700", mem_wcnt[56], c38 + 2);

        // Random traffic over 16 lines
        for (int n = 0; n < 80; n++) begin
            int unsigned l;
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                req(1'b1, 32'(l) * 32 + $urandom_range(0, 31), rnd_line(), lat, rd);
                chk("rnd_count_bound", wbuf_count_o <= CW'(DEPTH), 1);
            end else begin
                d = exp_line(l);
                req(1'b0, 32'(l) * 32 + $urandom_range(0, 31), '0, lat, rd);
                chk("rnd_rd_data", rd, d);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_empty("rnd_empty");
        for (int l = 0; l < 16; l++) begin
            if (sh_v[l]) chk("rnd_mem", mem_arr[l], sh_d[l]);
        end

        // Reset in the middle of a drain
        pv = sh_v[24];
        pd = sh_d[24];
        req(1'b1, 32'h0000_0300, {8{32'hBAD0_0300}}, lat, rd);
        wait_memen(w);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("mrst_mem_en", mem_enable_o, 0);
        chk("mrst_count", wbuf_count_o, 0);
        chk("mrst_empty", wbuf_empty_o, 1);
        chk("mrst_ack", cache_ack_o, 0);
        rst_i = 1'b1;
        sh_v[24] = pv;
        sh_d[24] = pd;
        tick();
        d = {8{32'hC0DE_0300}};
        req(1'b1, 32'h0000_0300, d, lat, rd);
        chk("post_rst_lat", lat, 1);
        wait_empty("post_rst_empty");
        chk("post_rst_mem", mem_arr[24], d);
        req(1'b0, 32'h0000_031F, '0, lat, rd);
        chk("post_rst_rd", rd, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Write-back buffer between the L1 dcache controller (upstream) and Data_Memory (downstream).
- Takes dirty-line evictions from the cache in 1 cycle and drains them to memory in the background.
- Serves line refills from memory, or forwards them from the buffer when the line is still pending.
- Shortens the dirty-miss penalty from two memory round trips to one.

Parameters:
- DEPTH, 4, number of 256-bit line entries (power of 2, ≥2).
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits (32-byte line; line address = addr[ADDR_W-1:5]).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-low reset.
- cache_enable_i  in  1  cache request valid; held until cache_ack_o.
- cache_write_i  in  1  1 = eviction write, 0 = refill read.
- cache_addr_i  in  ADDR_W  request byte address (low 5 bits ignored).
- cache_data_i  in  LINE_W  eviction line data.
- cache_ack_o  out  1  one-cycle request-complete pulse.
- cache_data_o  out  LINE_W  refill data, valid while cache_ack_o=1 for a read.
- mem_enable_o  out  1  memory request; held until mem_ack_i.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory byte address (low 5 bits = 0).
- mem_data_o  out  LINE_W  memory write data.
- mem_ack_i  in  1  memory completion.
- mem_data_i  in  LINE_W  memory read data, valid with mem_ack_i.
- wbuf_count_o  out  $clog2(DEPTH)+1  occupied entries.
- wbuf_empty_o  out  1  count==0 and no write in flight.

Behaviour:
- Reset (rst_i=0 at posedge):
  - FIFO cleared, FSM to IDLE.
  - cache_ack_o, mem_enable_o, mem_write_o = 0; cache_data_o, mem_addr_o, mem_data_o = 0; wbuf_count_o = 0; wbuf_empty_o = 1.
  - An in-flight memory transaction is abandoned; the bench resets memory alongside.
- Upstream acceptance: a request is sampled only when cache_enable_i=1, cache_ack_o=0 and no upstream request is already pending. In the ack cycle, enable is ignored, so no double accept.
- Eviction write, entry with same line address exists: coalesce (overwrite data in place). cache_ack_o=1 the next cycle; count unchanged.
- Eviction write, no match, not full: push at tail; ack next cycle; count+1.
- Eviction write, no match, full: hold the request (no ack) until a drain pops an entry. Push and ack follow in the cycle after the pop.
- Refill read, line matches an entry (WBUF_FORWARD_EN): cache_data_o = entry data; ack next cycle; no memory access.
- Refill read, no match: wait for the in-flight drain to finish (incl. GAP), then issue a memory read ahead of further drains (read priority).
  - cache_data_o = mem_data_i registered.
  - cache_ack_o rises the cycle after mem_ack_i.
- Memory FSM:
  - IDLE: pending read → READ; else count>0 → DRAIN (head entry); else stay.
  - DRAIN: mem_enable_o=1, mem_write_o=1, addr/data = head, all held stable. On mem_ack_i: pop head, → GAP.
  - READ: mem_enable_o=1, mem_write_o=0, addr held. On mem_ack_i: capture data, pulse cache_ack_o next cycle, → GAP.
  - GAP: mem_enable_o=0 for exactly 1 cycle, → IDLE.
- Head entry under drain is locked. A coalescing write to the head line is instead pushed as a new tail entry, or held if full. Forwarding from a locked head is allowed.
- Simultaneous pop and push in one cycle: count unchanged. Pointers wrap modulo DEPTH.
- wbuf_empty_o is combinational from count and FSM state.

Optional Feature:
- WBUF_FORWARD_EN defined: read hits in the buffer are forwarded, 1-cycle ack.
- Not defined: a read whose line matches any entry stalls until wbuf_empty_o=1, then reads memory. No read priority over drains in that case; coalescing is unchanged.

Test Plan:
- Single eviction, then idle (mem latency 10):
  - Write addr 0x0000_0200, data D1 → cache_ack_o at cycle+1, count=1.
  - mem write to 0x200 starts next cycle; ack at +10 → count=0, empty=1.
- Dirty miss:
  - Write 0x0400 D2, then read 0x0020 while the drain is in flight.
  - The read is issued after drain ack + GAP.
  - cache_data_o = memory[1] = 8888_9999_..._1111_0000.
- Forwarding (WBUF_FORWARD_EN):
  - Write 0x0040 D3, read 0x0044 before the drain ends → ack next cycle, data D3, no mem read.
  - Without the macro: read waits for empty, then returns D3 from memory.
- Full FIFO, DEPTH=4:
  - Write 5 distinct lines back-to-back → 5th held without ack until the first drain ack.
  - 5th acked 1 cycle after the pop; count stays 4.
- Coalesce:
  - Write 0x0600 DA then 0x0600 DB while 0x0600 is not the head → count +1 only.
  - Memory ends with DB at line 0x0600.
- Reset mid-drain: rst_i=0 during DRAIN → next posedge mem_enable_o=0, count=0, empty=1, cache_ack_o=0.
